display_scan_7seg: RTL and testbench
====================================

DISPLAY_SCAN_7SEG -- requirements
Module: display_scan_7seg

Interface
REQ-001 The block SHALL have a parameter N_DIGITS, default 8, giving the number of multiplexed digits (1..16).
REQ-002 The block SHALL have a parameter REFRESH_DIV, default 100000, giving the clock cycles per digit slot (>= 2).
REQ-003 The block SHALL have a parameter GUARD_CYCLES, default 16, giving the anode-off cycles at the start of each slot (< REFRESH_DIV).
REQ-004 The block SHALL have a parameter BLANK_LZ, default 1, which when set enables leading-zero blanking.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk, input, 1 bit, single clock; all state on rising edge.
REQ-006 The block SHALL have the port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have the port value_in, input, 4*N_DIGITS bits, hex nibbles, where nibble i (bits 4i+3:4i) is digit i and digit 0 is rightmost.
REQ-008 The block SHALL have the port dp_in, input, N_DIGITS bits, decimal point per digit, active-high.
REQ-009 The block SHALL have the port digit_en, input, N_DIGITS bits, per-digit enable; a disabled digit stays dark for its whole slot.
REQ-010 The block SHALL have the port load, input, 1 bit, which captures value_in/dp_in into the pending register.
REQ-011 The block SHALL have the port segments, output, 7 bits, active-low, bit 6 = a ... bit 0 = g.
REQ-012 The block SHALL have the port dp, output, 1 bit, active-low decimal point.
REQ-013 The block SHALL have the port anodes, output, N_DIGITS bits, active-low digit select, at most one bit low at a time.
REQ-014 The block SHALL have the port frame_start, output, 1 bit, a one-cycle pulse when the digit index wraps to 0.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the terminal count SHALL advance the digit index idx by one, wrapping N_DIGITS-1 -> 0.
REQ-016 The decode SHALL be, with active-high abcdefg values shown and the output inverted: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
REQ-017 All outputs SHALL be registered and reflect the idx/prescaler state of the previous cycle, giving one cycle of latency.
REQ-018 While prescaler < GUARD_CYCLES, anodes SHALL be all ones and segments/dp all ones (ghosting guard).
REQ-019 Outside the guard window, anodes[idx] SHALL be 0 iff digit_en[idx]=1 and the digit is not blanked.
REQ-020 With BLANK_LZ=1, digit i>0 SHALL be blanked when display nibbles i..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked; dp_in of a blanked digit SHALL be ignored.
REQ-021 load=1 SHALL copy value_in/dp_in to the pending registers and set pend; a later load before the boundary SHALL overwrite the pending registers.
REQ-022 At a frame boundary (terminal count with idx=N_DIGITS-1), if pend=1 the pending registers SHALL transfer to the display registers and pend SHALL clear, so the display never tears mid-frame.
REQ-023 When load and the frame boundary coincide, value_in/dp_in SHALL go directly to the display registers and pend SHALL clear.
REQ-024 frame_start SHALL pulse for one cycle, coincident with anodes switching to digit 0 (one cycle after the boundary).
REQ-025 digit_en SHALL be sampled live, not shadowed.

Reset
REQ-026 While rst_n=0, the block SHALL force: prescaler=0, idx=0, pend=0, display/pending registers=0, anodes=all ones, segments=7'h7F, dp=1, frame_start=0.
REQ-027 On reset release, scanning SHALL start at digit 0 with a guard window.
REQ-028 A reset asserted mid-slot SHALL take effect immediately and asynchronously, and any pending load SHALL be discarded.

Verification
Bench parameters: N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, BLANK_LZ=1.
REQ-029 Scenario: load 16'h12AF, dp_in=4'b0100, digit_en=4'hF, then run 2 frames -> the second frame shows digits 0..3 with segments ~47, ~77, ~6D (dp=0), ~30; each anode is low for 3 cycles, then all high for 1 cycle.
REQ-030 Scenario: load 16'h0005 -> digits 1..3 are never selected; digit 0 shows ~5B; frame_start pulses every 16 cycles.
REQ-031 Scenario: load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the display switches to 2222 exactly at frame_start and never shows 1111.
REQ-032 Scenario: load asserted on the boundary cycle with 16'h3333 -> the frame starting next shows 3333 and pend=0.
REQ-033 Scenario: digit_en=4'b1010 with 16'h8888 -> only anodes[1] and anodes[3] ever go low, each showing ~7F.
REQ-034 Scenario: rst_n pulsed low during a digit-2 slot -> outputs reach reset values within the same cycle; after release, the first non-guard cycle selects digit 0 with value 0 (~7E).

Source files
------------

// File: rtl/display_scan_7seg.sv
// display_scan_7seg: time-multiplexed driver for a common-anode 7-segment
// display with a per-slot ghosting guard, leading-zero blanking and
// frame-synchronous (tear-free) value updates.
//
// Ports:
//   clk          - single clock, all state on the rising edge
//   rst_n        - asynchronous active-low reset
//   value_in     - 4*N_DIGITS bits, nibble i is digit i (digit 0 rightmost)
//   dp_in        - per-digit decimal point, active-high
//   digit_en     - per-digit enable, sampled live
//   load         - captures value_in/dp_in, applied at the next frame boundary
//   segments     - active-low segments, bit 6 = a ... bit 0 = g
//   dp           - active-low decimal point
//   anodes       - active-low digit select, at most one bit low
//   frame_start  - one-cycle pulse as the scan returns to digit 0
module display_scan_7seg #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned BLANK_LZ     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_start
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VW = 4 * N_DIGITS;

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                pend;
    logic                wrap;
    logic [VW-1:0]       disp_val;
    logic [VW-1:0]       pend_val;
    logic [N_DIGITS-1:0] disp_dp;
    logic [N_DIGITS-1:0] pend_dp;

    logic                slot_end;
    logic                frame_end;
    logic                guard;
    logic                lit;
    logic [3:0]          nib;
    logic [N_DIGITS-1:0] blank;
    logic [N_DIGITS-1:0] anode_nx;

    // Hex digit to active-high abcdefg pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'h7E;
            4'h1:    seg_decode = 7'h30;
            4'h2:    seg_decode = 7'h6D;
            4'h3:    seg_decode = 7'h79;
            4'h4:    seg_decode = 7'h33;
            4'h5:    seg_decode = 7'h5B;
            4'h6:    seg_decode = 7'h5F;
            4'h7:    seg_decode = 7'h70;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h7B;
            4'hA:    seg_decode = 7'h77;
            4'hB:    seg_decode = 7'h1F;
            4'hC:    seg_decode = 7'h4E;
            4'hD:    seg_decode = 7'h3D;
            4'hE:    seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

    assign slot_end  = (presc == PW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));
    assign guard     = (presc < PW'(GUARD_CYCLES));
    assign nib       = disp_val[{idx, 2'b00} +: 4];
    assign lit       = !guard && digit_en[idx] && !blank[idx];

    // A digit above 0 is blank when it and every digit to its left are zero.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
            blank[i]   = (BLANK_LZ != 0) && zero_above;
        end
    end

    // Active-low one-cold anode pattern for the current slot.
    always_comb begin
        anode_nx = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            anode_nx[i] = !(lit && (idx == IW'(i)));
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= frame_end;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Pending/display double buffer; display only changes on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else if (frame_end && load) begin
            disp_val <= value_in;
            disp_dp  <= dp_in;
            pend     <= 1'b0;
        end else if (frame_end && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            pend     <= 1'b0;
        end else if (load) begin
            pend_val <= value_in;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
        end
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes      <= '1;
            segments    <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anodes      <= anode_nx;
            segments    <= lit ? ~seg_decode(nib) : 7'h7F;
            dp          <= !(lit && disp_dp[idx]);
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scan_7seg.sv
// tb_display_scan_7seg: directed, table-driven check of display_scan_7seg
// with N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, BLANK_LZ=1.
// Each record holds a display value and the per-digit expected active-low
// segment/dp pattern; a frame is checked cycle by cycle from frame_start.
module tb_display_scan_7seg;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_start;

    int checks;
    int errors;

    display_scan_7seg #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4),
        .GUARD_CYCLES(1),
        .BLANK_LZ    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .segments   (segments),
        .dp         (dp),
        .anodes     (anodes),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic [3:0]      en;
        logic [3:0][6:0] seg;   // expected active-low segments per digit
        logic [3:0]      dpo;   // expected active-low dp per digit
        logic [3:0]      on;    // digits expected to light
    } rec_t;

    function automatic rec_t mk(input logic [15:0] val, input logic [3:0] dpi,
                                input logic [3:0] en, input logic [27:0] seg,
                                input logic [3:0] dpo, input logic [3:0] on);
        rec_t r;
        r.val = val;
        r.dpi = dpi;
        r.en  = en;
        r.seg = seg;
        r.dpo = dpo;
        r.on  = on;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_wait: got %b after 40 cycles, required 1", frame_start);
        end
    endtask

    // Starts on the negedge where frame_start is expected high, checks 16
    // cycles, returns on the negedge of the next frame's first cycle.
    // Optional loads are driven from cycle la / lb for one cycle.
    task automatic check_frame(input string tag, input rec_t r,
                               input int la, input logic [15:0] va, input logic [3:0] da,
                               input int lb, input logic [15:0] vb, input logic [3:0] db);
        for (int c = 0; c < 16; c++) begin
            int         s;
            logic       l;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            s  = c / 4;
            l  = (c % 4 != 0) && r.on[s];
            ea = l ? ~(4'b0001 << s) : 4'hF;
            es = l ? r.seg[s] : 7'h7F;
            ed = l ? r.dpo[s] : 1'b1;
            chk($sformatf("%s c%0d anodes", tag, c), 16'(anodes), 16'(ea));
            chk($sformatf("%s c%0d segments", tag, c), 16'(segments), 16'(es));
            chk($sformatf("%s c%0d dp", tag, c), 16'(dp), 16'(ed));
            chk($sformatf("%s c%0d frame_start", tag, c), 16'(frame_start), 16'(c == 0));
            load     = (c == la) || (c == lb);
            value_in = (c == lb) ? vb : va;
            dp_in    = (c == lb) ? db : da;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    rec_t vec [7];
    rec_t r_zero, r_2222, r_3333, prev;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        digit_en = 4'hF;

        vec[0] = mk(16'h12AF, 4'b0100, 4'hF, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1011, 4'b1111);
        vec[1] = mk(16'h0005, 4'b0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h24}, 4'b1111, 4'b0001);
        vec[2] = mk(16'h8888, 4'b0000, 4'b1010, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111, 4'b1010);
        vec[3] = mk(16'h0000, 4'b1111, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1110, 4'b0001);
        vec[4] = mk(16'h0B0D, 4'b1010, 4'hF, {7'h7F, 7'h60, 7'h01, 7'h42}, 4'b1101, 4'b0111);
        vec[5] = mk(16'h9476, 4'b0001, 4'b0111, {7'h04, 7'h4C, 7'h0F, 7'h20}, 4'b1110, 4'b0111);
        vec[6] = mk(16'hCE38, 4'b0000, 4'hF, {7'h31, 7'h30, 7'h06, 7'h00}, 4'b1111, 4'b1111);
        r_zero = mk(16'h0000, 4'b0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111, 4'b0001);
        r_2222 = mk(16'h2222, 4'b0000, 4'hF, {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111, 4'b1111);
        r_3333 = mk(16'h3333, 4'b0000, 4'hF, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b1111, 4'b1111);

        // Reset values, then first cycles after release.
        repeat (3) @(negedge clk);
        chk("rst anodes", 16'(anodes), 16'hF);
        chk("rst segments", 16'(segments), 16'h7F);
        chk("rst dp", 16'(dp), 16'h1);
        chk("rst frame_start", 16'(frame_start), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst guard anodes", 16'(anodes), 16'hF);
        @(negedge clk);
        chk("post_rst digit0 anodes", 16'(anodes), 16'hE);
        chk("post_rst digit0 segments", 16'(segments), 16'h01);
        wait_fs();

        // Table: load during frame N at cycle 2, expect it in frame N+1.
        prev = r_zero;
        for (int i = 0; i < 7; i++) begin
            check_frame($sformatf("v%0d_prev", i), prev, 2, vec[i].val, vec[i].dpi, -1, '0, '0);
            digit_en = vec[i].en;
            check_frame($sformatf("v%0d", i), vec[i], -1, '0, '0, -1, '0, '0);
            prev = vec[i];
        end

        // Two loads before the boundary: the second wins, first never shown.
        check_frame("ovw_prev", prev, 3, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);
        check_frame("ovw", r_2222, -1, '0, '0, -1, '0, '0);

        // Load coinciding with the boundary goes straight to the display and
        // leaves nothing pending (stale 2222 must not reappear).
        check_frame("bnd_prev", r_2222, 14, 16'h3333, 4'h0, -1, '0, '0);
        check_frame("bnd", r_3333, -1, '0, '0, -1, '0, '0);
        check_frame("bnd_hold", r_3333, -1, '0, '0, -1, '0, '0);

        // Pending load, then asynchronous reset in the middle of digit 2.
        load     = 1'b1;
        value_in = 16'h4444;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid digit2 anodes", 16'(anodes), 16'hB);
        chk("mid digit2 segments", 16'(segments), 16'h06);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst anodes", 16'(anodes), 16'hF);
        chk("async rst segments", 16'(segments), 16'h7F);
        chk("async rst dp", 16'(dp), 16'h1);
        chk("async rst frame_start", 16'(frame_start), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst guard anodes", 16'(anodes), 16'hF);
        @(negedge clk);
        chk("rerst digit0 anodes", 16'(anodes), 16'hE);
        chk("rerst digit0 segments", 16'(segments), 16'h01);
        wait_fs();
        check_frame("rerst", r_zero, -1, '0, '0, -1, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
